rl_lj_pair_scheduler: RTL
=========================

# rl_lj_pair_scheduler

Sequences one home-cell evaluation for the range-limited LJ force pipeline. It fetches particle counts for the home cell and its 13 half-shell neighbour cells and emits every (reference, neighbour) particle-address pair exactly once to the filter front end, using a valid/ready handshake. It signals per-reference completion and whole-home-cell completion (`out_home_cell_evaluation_done`). It sits between the top-level `start` control and the filter/arbiter stage.

## Interface
Parameters:
- `NUM_NEIGHBOR_CELLS`, 13, neighbour cells per home cell (half-shell).
- `CELL_ADDR_WIDTH`, 7, width of in-cell particle address and particle count.
- `MAX_CELL_PARTICLE_NUM`, 100, largest legal cell count; larger inputs are illegal.
- `CELL_SEL_WIDTH`, 4, width of cell select; must satisfy 2^CELL_SEL_WIDTH > NUM_NEIGHBOR_CELLS.

Ports:
- `clk`  in  1  clock; the single clock for the block.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  begin evaluation; sampled only in IDLE or DONE.
- `out_count_cell_sel`  out  CELL_SEL_WIDTH  cell whose count is requested; 0 = home cell, 1..NUM_NEIGHBOR_CELLS = neighbour cells.
- `in_cell_particle_num`  in  CELL_ADDR_WIDTH  count of the selected cell; valid exactly 1 cycle after `out_count_cell_sel` changes.
- `out_pair_valid`  out  1  pair outputs valid.
- `in_pair_ready`  in  1  filter stage accepts the pair.
- `out_ref_addr`  out  CELL_ADDR_WIDTH  reference particle address in the home cell.
- `out_nb_cell`  out  CELL_SEL_WIDTH  neighbour particle's cell (0 = home).
- `out_nb_addr`  out  CELL_ADDR_WIDTH  neighbour particle address.
- `out_ref_done`  out  1  1-cycle pulse when all pairs of the current reference particle have been issued.
- `out_busy`  out  1  high from leaving IDLE/DONE until entering DONE.
- `out_home_cell_evaluation_done`  out  1  high in DONE; stays high until the next accepted `start`.

## Operation
- Registers: `home_num`, `nb_num`, `ref` (i), `cell` (c), `nb` (j).
- States:
  - IDLE: `start` moves to FETCH_HOME.
  - FETCH_HOME: sel=0.
  - LOAD_HOME: captures `home_num`. If it is 0, go to DONE; otherwise i=0, c=0, go to FETCH_NB.
  - FETCH_NB: sel=c.
  - LOAD_NB: captures `nb_num` and sets j_start = (c==0) ? i+1 : 0. If j_start >= `nb_num`, perform ADVANCE; otherwise j=j_start and go to ISSUE.
  - ISSUE: `out_pair_valid`=1 with (i, c, j). On valid&ready: if j==`nb_num`-1, perform ADVANCE; otherwise j++.
  - DONE: `start` moves to FETCH_HOME.
- ADVANCE (performed in the same cycle as the transition):
  - If c < NUM_NEIGHBOR_CELLS: c++ and go to FETCH_NB.
  - Otherwise pulse `out_ref_done`. If i==`home_num`-1, go to DONE; else i++, c=0, go to FETCH_NB.
- The home cell is re-fetched for every reference particle; the count source must be stable for the whole evaluation.
- Pair order is i outer, c middle, j inner, all ascending. Home-cell pairs with j <= i are never emitted (Newton's third law).
- Total pairs = N(N-1)/2 + N·Σn_k, where N = home count and n_k = neighbour cell counts.
- `start` while busy is ignored. `start` held high in DONE restarts immediately.
- Reset (any state, any cycle): next state IDLE, all counters 0, every output 0. The pair in flight is dropped.

## Timing
- Outputs are registered and derived from state/counters only.
- Start latency:
  - `start` sampled at T (IDLE).
  - T+1 FETCH_HOME, sel=0.
  - T+2 LOAD_HOME.
  - T+3 FETCH_NB, sel=0.
  - T+4 LOAD_NB.
  - T+5 first `out_pair_valid` (if non-empty).
- A transfer occurs on a rising edge with valid&ready. One pair per cycle while ready=1.
- While valid=1 and ready=0, all pair outputs hold stable. Valid never deasserts without a transfer, except on reset.
- Cell switch overhead: 2 cycles (FETCH_NB+LOAD_NB) per cell, including empty cells.
- `out_ref_done` asserts in the cycle ADVANCE leaves the last cell of i. It may coincide with the last transfer's following cycle but never with valid for the next reference.
- `out_busy` and `out_home_cell_evaluation_done` are never high together. Done rises in the cycle after the final ADVANCE.

## Test plan
- Reset mid-stream: during ISSUE, drive rst=0 for 2 cycles -> all outputs 0 on the next edge; state IDLE; no pairs until a new `start`.
- Home only: N=3, all neighbour counts 0, ready=1 -> exactly pairs (0,0,1), (0,0,2), (1,0,2); `out_ref_done` pulses 3 times; done rises; 3 transfers total.
- Single neighbour: N=2, cell 5 count 4, others 0 -> 9 pairs in order: (0,0,1), (0,5,0..3), (1,5,0..3).
- Backpressure: same stimulus as the single-neighbour case with ready alternating 1,0 and random stalls -> outputs stable during stalls; exactly 9 unique pairs; no duplicates.
- Empty home: N=0 -> done at T+3; `out_pair_valid` never asserted; `out_ref_done` never pulses.
- Full load and restart: N=100, all neighbours 100 -> 4950+130000=134950 pairs. `start` pulses while busy are ignored. `start` in DONE yields a second identical run and clears done at T+1.

Source files
------------

// File: rtl/rl_lj_pair_scheduler.sv
// Home-cell pair scheduler: fetches home/neighbour particle counts and issues every
// (reference, neighbour) particle pair once over a valid/ready handshake.
module rl_lj_pair_scheduler #(
    parameter int unsigned NUM_NEIGHBOR_CELLS    = 13,
    parameter int unsigned CELL_ADDR_WIDTH       = 7,
    parameter int unsigned MAX_CELL_PARTICLE_NUM = 100,
    parameter int unsigned CELL_SEL_WIDTH        = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [CELL_SEL_WIDTH-1:0]  out_count_cell_sel,
    input  logic [CELL_ADDR_WIDTH-1:0] in_cell_particle_num,
    output logic                       out_pair_valid,
    input  logic                       in_pair_ready,
    output logic [CELL_ADDR_WIDTH-1:0] out_ref_addr,
    output logic [CELL_SEL_WIDTH-1:0]  out_nb_cell,
    output logic [CELL_ADDR_WIDTH-1:0] out_nb_addr,
    output logic                       out_ref_done,
    output logic                       out_busy,
    output logic                       out_home_cell_evaluation_done
);

    localparam int unsigned AW1 = CELL_ADDR_WIDTH + 1;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_FETCH_HOME = 3'd1;
    localparam logic [2:0] S_LOAD_HOME  = 3'd2;
    localparam logic [2:0] S_FETCH_NB   = 3'd3;
    localparam logic [2:0] S_LOAD_NB    = 3'd4;
    localparam logic [2:0] S_ISSUE      = 3'd5;
    localparam logic [2:0] S_DONE       = 3'd6;

    localparam logic [CELL_SEL_WIDTH-1:0]  LAST_CELL = CELL_SEL_WIDTH'(NUM_NEIGHBOR_CELLS);
    localparam logic [CELL_ADDR_WIDTH-1:0] MAX_NUM   = CELL_ADDR_WIDTH'(MAX_CELL_PARTICLE_NUM);

    logic [2:0]                 state_q, state_d;
    logic [CELL_ADDR_WIDTH-1:0] home_num_q, home_num_d;
    logic [CELL_ADDR_WIDTH-1:0] nb_num_q, nb_num_d;
    logic [CELL_ADDR_WIDTH-1:0] ref_q, ref_d;
    logic [CELL_SEL_WIDTH-1:0]  cell_q, cell_d;
    logic [CELL_ADDR_WIDTH-1:0] nb_q, nb_d;
    logic [CELL_SEL_WIDTH-1:0]  sel_q, sel_d;
    logic                       valid_q, valid_d;
    logic                       ref_done_q, ref_done_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic [CELL_ADDR_WIDTH-1:0] count_c;
    logic [AW1-1:0]             j_start_c;
    logic                       advance_c;

    // Out-of-range counts are illegal; clamp so counters can never run past the cell size.
    assign count_c = (in_cell_particle_num > MAX_NUM) ? MAX_NUM : in_cell_particle_num;

    always_comb begin
        state_d    = state_q;
        home_num_d = home_num_q;
        nb_num_d   = nb_num_q;
        ref_d      = ref_q;
        cell_d     = cell_q;
        nb_d       = nb_q;
        ref_done_d = 1'b0;
        advance_c  = 1'b0;
        j_start_c  = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_FETCH_HOME;
            end
            S_FETCH_HOME: state_d = S_LOAD_HOME;
            S_LOAD_HOME: begin
                home_num_d = count_c;
                if (count_c == '0) begin
                    state_d = S_DONE;
                end else begin
                    ref_d   = '0;
                    cell_d  = '0;
                    state_d = S_FETCH_NB;
                end
            end
            S_FETCH_NB: state_d = S_LOAD_NB;
            S_LOAD_NB: begin
                nb_num_d  = count_c;
                // Home-cell pairs start above the reference so each pair is issued once.
                j_start_c = (cell_q == '0) ? AW1'(ref_q) + AW1'(1) : '0;
                if (j_start_c >= AW1'(count_c)) begin
                    advance_c = 1'b1;
                end else begin
                    nb_d    = CELL_ADDR_WIDTH'(j_start_c);
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (in_pair_ready) begin
                    if (nb_q == nb_num_q - CELL_ADDR_WIDTH'(1)) advance_c = 1'b1;
                    else                                         nb_d = nb_q + CELL_ADDR_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (advance_c) begin
            if (cell_q < LAST_CELL) begin
                cell_d  = cell_q + CELL_SEL_WIDTH'(1);
                state_d = S_FETCH_NB;
            end else begin
                ref_done_d = 1'b1;
                if (ref_q == home_num_q - CELL_ADDR_WIDTH'(1)) begin
                    state_d = S_DONE;
                end else begin
                    ref_d   = ref_q + CELL_ADDR_WIDTH'(1);
                    cell_d  = '0;
                    state_d = S_FETCH_NB;
                end
            end
        end
    end

    // Output flops follow the next state so they line up with the state they describe.
    always_comb begin
        valid_d = (state_d == S_ISSUE);
        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d  = (state_d == S_DONE);
        case (state_d)
            S_FETCH_HOME: sel_d = '0;
            S_FETCH_NB:   sel_d = cell_d;
            default:      sel_d = sel_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            home_num_q <= '0;
            nb_num_q   <= '0;
            ref_q      <= '0;
            cell_q     <= '0;
            nb_q       <= '0;
            sel_q      <= '0;
            valid_q    <= 1'b0;
            ref_done_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            home_num_q <= home_num_d;
            nb_num_q   <= nb_num_d;
            ref_q      <= ref_d;
            cell_q     <= cell_d;
            nb_q       <= nb_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
            ref_done_q <= ref_done_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign out_count_cell_sel            = sel_q;
    assign out_pair_valid                = valid_q;
    assign out_ref_addr                  = ref_q;
    assign out_nb_cell                   = cell_q;
    assign out_nb_addr                   = nb_q;
    assign out_ref_done                  = ref_done_q;
    assign out_busy                      = busy_q;
    assign out_home_cell_evaluation_done = done_q;

endmodule
